// File: rtl/result_tx_streamer_pkg.sv
// Shared constants and FSM encoding for the result matrix streamer.
package result_tx_streamer_pkg;
  localparam int         ADDR_W   = 4;
  localparam int         DATA_W   = 8;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [1:0] RES_SEL  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CKSUM,
    ST_FIN
  } state_e;
endpackage

// File: rtl/result_tx_streamer_if.sv
// Byte valid/ready link from the streamer to the UART transmitter.
interface result_tx_streamer_if;
  import result_tx_streamer_pkg::*;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/result_tx_streamer_sync_byte_fifo.sv
// Power-of-two circular FIFO; push and pop in the same cycle are legal at any fill level.
module sync_byte_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot, so a push into a full FIFO is fine in that cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/result_tx_streamer.sv
// Streams the N x N result matrix as header, row-major data bytes and an 8-bit checksum.
module result_tx_streamer
  import result_tx_streamer_pkg::*;
#(
  parameter int N          = 10,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [1:0]            mem_matrix_select,
  output logic [ADDR_W-1:0]     mem_row,
  output logic [ADDR_W-1:0]     mem_col,
  input  logic [DATA_W-1:0]     mem_read_data,
  result_tx_streamer_if.master  tx,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            byte_count
);
  localparam int TOTAL = N * N;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DCW   = $clog2(TOTAL + 1);

  state_e             state_q;
  logic [ADDR_W-1:0]  row_q, col_q;
  logic               rd_active_q;
  logic [RD_LAT-1:0]  pipe_q;
  logic [RD_LAT:0]    pipe_d;
  logic [CW-1:0]      inflight_q;
  logic [CW-1:0]      fifo_cnt;
  logic [CW:0]        used;
  logic [DATA_W-1:0]  fifo_dout, cksum_q;
  logic [DCW-1:0]     data_cnt_q;
  logic [7:0]         byte_cnt_q;
  logic               busy_q, done_q;
  logic               fifo_full, fifo_empty;
  logic               issue, push, pop, accept;

  assign mem_matrix_select = RES_SEL;
  assign mem_row    = row_q;
  assign mem_col    = col_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_count = byte_cnt_q;

  // Credits cover both buffered bytes and reads still in the memory pipeline.
  assign used   = {1'b0, fifo_cnt} + {1'b0, inflight_q};
  assign issue  = (state_q == ST_HDR || state_q == ST_DATA) && rd_active_q &&
                  !fifo_full && (used < (CW+1)'(FIFO_DEPTH));
  assign pipe_d = {pipe_q, issue};
  assign push   = pipe_q[RD_LAT-1];
  assign pop    = (state_q == ST_DATA) && !fifo_empty && tx.tx_ready;
  assign accept = tx.tx_valid && tx.tx_ready;

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .din_i   (mem_read_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    case (state_q)
      ST_HDR:   begin tx.tx_valid = 1'b1;        tx.tx_data = HDR_BYTE; end
      ST_DATA:  begin tx.tx_valid = !fifo_empty; tx.tx_data = fifo_empty ? '0 : fifo_dout; end
      ST_CKSUM: begin tx.tx_valid = 1'b1;        tx.tx_data = cksum_q; end
      default:  ;
    endcase
  end

  // Read address generator and memory-latency tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      rd_active_q <= 1'b0;
      pipe_q      <= '0;
      inflight_q  <= '0;
    end else begin
      pipe_q <= pipe_d[RD_LAT-1:0];
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
      if (state_q == ST_IDLE && start) begin
        row_q       <= '0;
        col_q       <= '0;
        rd_active_q <= 1'b1;
      end else if (issue) begin
        if (col_q == ADDR_W'(N-1)) begin
          col_q <= '0;
          if (row_q == ADDR_W'(N-1)) rd_active_q <= 1'b0;
          else                       row_q       <= row_q + ADDR_W'(1);
        end else begin
          col_q <= col_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
      cksum_q    <= '0;
      data_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) byte_cnt_q <= byte_cnt_q + 8'd1;
      case (state_q)
        ST_IDLE: if (start) begin
          state_q    <= ST_HDR;
          busy_q     <= 1'b1;
          byte_cnt_q <= '0;
          cksum_q    <= '0;
          data_cnt_q <= '0;
        end
        ST_HDR: if (accept) state_q <= ST_DATA;
        ST_DATA: if (accept) begin
          cksum_q    <= cksum_q + tx.tx_data;
          data_cnt_q <= data_cnt_q + DCW'(1);
          if (data_cnt_q == DCW'(TOTAL-1)) state_q <= ST_CKSUM;
        end
        ST_CKSUM: if (accept) begin
          state_q <= ST_FIN;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_tx_streamer.sv
// Directed + randomized bench: expected frame built from memory contents and framing rules.
module tb_result_tx_streamer;
  import result_tx_streamer_pkg::*;

  localparam int N = 10, RD_LAT = 1, FIFO_DEPTH = 4, TOTAL = N * N;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] mem_matrix_select;
  logic [3:0] mem_row, mem_col;
  logic [7:0] mem_read_data;
  logic       busy, done;
  logic [7:0] byte_count;

  result_tx_streamer_if tx_if ();

  result_tx_streamer #(.N(N), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .mem_matrix_select (mem_matrix_select),
    .mem_row           (mem_row),
    .mem_col           (mem_col),
    .mem_read_data     (mem_read_data),
    .tx                (tx_if),
    .busy              (busy),
    .done              (done),
    .byte_count        (byte_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_arr [N][N];
  always @(posedge clk) begin
    if (int'(mem_row) < N && int'(mem_col) < N) mem_read_data <= mem_arr[mem_row][mem_col];
    else                                        mem_read_data <= 8'h00;
  end

  int         total = 0, bad = 0;
  logic [7:0] got [$];
  int         done_cnt = 0, ready_mode = 0, stall_n = 0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: at the falling edge choose tx_ready, then record what the next rising edge transfers.
  task automatic tick();
    @(negedge clk);
    case (ready_mode)
      0: tx_if.tx_ready = 1'b1;
      1: tx_if.tx_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (got.size() < 5) tx_if.tx_ready = 1'b1;
        else if (stall_n < 20) begin tx_if.tx_ready = 1'b0; stall_n++; end
        else tx_if.tx_ready = ~tx_if.tx_ready;
      end
    endcase
    if (reset) begin
      pv = 1'b0; pr = 1'b0;
    end else begin
      if (pv && !pr) chk("stall_hold", {tx_if.tx_valid, tx_if.tx_data}, {1'b1, pd});
      chk("credit_bound", int'(dut.fifo_cnt) + int'(dut.inflight_q) <= FIFO_DEPTH, 1);
      if (done) done_cnt++;
      if (tx_if.tx_valid && tx_if.tx_ready) got.push_back(tx_if.tx_data);
      pv = tx_if.tx_valid; pr = tx_if.tx_ready; pd = tx_if.tx_data;
    end
  endtask

  task automatic fill(input int pat);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (pat)
          0:       mem_arr[r][c] = 8'(r * 10 + c);
          1:       mem_arr[r][c] = 8'hFF;
          default: mem_arr[r][c] = 8'($urandom);
        endcase
  endtask

  task automatic run_frame(input string tag, input int rmode, input bit repulse);
    logic [7:0] exp [$];
    logic [7:0] sum;
    int         budget;
    bit         pulsed;
    exp = {}; sum = 8'h00; pulsed = 1'b0;
    exp.push_back(8'hA5);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exp.push_back(mem_arr[r][c]);
        sum = sum + mem_arr[r][c];
      end
    exp.push_back(sum);
    got = {}; done_cnt = 0; ready_mode = rmode; stall_n = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, "_first_addr"}, {mem_row, mem_col}, 8'h00);
    chk({tag, "_busy_set"}, busy, 1'b1);
    chk({tag, "_bytecnt_clr"}, byte_count, 8'd0);
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      if (repulse && !pulsed && got.size() >= 30) begin start = 1'b1; pulsed = 1'b1; end
      tick();
      start = 1'b0;
      budget++;
    end
    chk({tag, "_done_in_time"}, budget < 3000, 1);
    repeat (6) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_clr"}, busy, 1'b0);
    chk({tag, "_byte_count"}, byte_count, 8'(TOTAL + 2));
    chk({tag, "_length"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
  endtask

  initial begin
    int budget;
    reset = 1'b1; start = 1'b0; tx_if.tx_ready = 1'b0;
    fill(0);
    #3;
    chk("rst_sel", mem_matrix_select, 2'd2);
    chk("rst_outs", {tx_if.tx_valid, tx_if.tx_data, busy, done, byte_count, mem_row, mem_col}, '0);
    repeat (50) begin
      tick();
      chk("rst_quiet", {tx_if.tx_valid, busy, done}, 3'b000);
    end
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_quiet", {tx_if.tx_valid, busy, done, byte_count}, '0);

    run_frame("ramp", 0, 1'b0);
    run_frame("stall", 2, 1'b0);
    fill(1);
    run_frame("ones", 0, 1'b0);
    fill(0);
    run_frame("repulse", 1, 1'b1);
    fill(2);
    run_frame("rand_a", 1, 1'b0);
    fill(2);
    run_frame("rand_b", 1, 1'b0);

    // Reset mid-frame, applied between clock edges.
    fill(0);
    got = {}; ready_mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    budget = 0;
    while (got.size() < 40 && budget < 500) begin tick(); budget++; end
    chk("mid_reached40", budget < 500, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_outs", {tx_if.tx_valid, tx_if.tx_data, busy, done, byte_count, mem_row, mem_col}, '0);
    chk("mid_rst_sel", mem_matrix_select, 2'd2);
    chk("mid_rst_flush", {dut.fifo_cnt, dut.inflight_q}, '0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    fill(2);
    run_frame("after_rst", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
